// File: rtl/solitaire_move_ctrl.sv
// solitaire_move_ctrl: debounced cursor and jump-request initiator; `define SOLITAIRE_MOVE_COUNT_EN adds move_count
module solitaire_move_ctrl #(
    parameter int BOARD_WIDTH     = 7,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    output logic       move_valid,
    input  logic       move_ready,
    output logic [2:0] piece_x,
    output logic [2:0] piece_y,
    output logic [1:0] direction,
    input  logic       resp_valid,
    input  logic       resp_ok,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       armed,
    output logic       busy,
    output logic       last_ok,
    output logic       last_err
`ifdef SOLITAIRE_MOVE_COUNT_EN
    ,
    output logic [5:0] move_count
`endif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic [1:0] {NAV, ARMED, ISSUE, WAIT} state_t;
    state_t          r_state;
    logic [4:0]      w_raw;
    logic [4:0]      r_db;
    logic [4:0]      r_press;
    logic [CW-1:0]   r_cnt [5];
    logic            w_sel;
    logic            w_dir_ev;
    logic [1:0]      w_dir;
    logic [3:0]      w_tx;
    logic [3:0]      w_ty;
    logic            w_hole_ok;
    logic [2:0]      w_lx;
    logic [2:0]      w_ly;
    assign w_raw = {btn_sel, btn_down, btn_up, btn_right, btn_left};
    // r_press pulses on the same edge the debounced level rises
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db    <= '0;
            r_press <= '0;
            for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                r_press[i] <= 1'b0;
                if (w_raw[i] == r_db[i]) r_cnt[i] <= '0;
                else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_db[i]    <= w_raw[i];
                    r_press[i] <= w_raw[i];
                    r_cnt[i]   <= '0;
                end else r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end
    always_comb begin
        w_sel     = r_press[4];
        w_dir_ev  = !r_press[4] && |r_press[3:0];
        w_dir     = r_press[0] ? 2'd0 : r_press[1] ? 2'd1 : r_press[2] ? 2'd2 : 2'd3;
        w_tx      = {1'b0, cursor_x} + (w_dir == 2'd0 ? 4'hF : w_dir == 2'd1 ? 4'd1 : 4'd0);
        w_ty      = {1'b0, cursor_y} + (w_dir == 2'd2 ? 4'hF : w_dir == 2'd3 ? 4'd1 : 4'd0);
        w_hole_ok = w_tx < 4'(BOARD_WIDTH) && w_ty < 4'(BOARD_WIDTH) &&
                    ((w_tx >= 4'd2 && w_tx <= 4'd4) || (w_ty >= 4'd2 && w_ty <= 4'd4));
        w_lx      = piece_x + (direction == 2'd0 ? 3'd6 : direction == 2'd1 ? 3'd2 : 3'd0);
        w_ly      = piece_y + (direction == 2'd2 ? 3'd6 : direction == 2'd3 ? 3'd2 : 3'd0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= NAV;
            cursor_x   <= 3'd3;
            cursor_y   <= 3'd3;
            piece_x    <= 3'd3;
            piece_y    <= 3'd3;
            direction  <= 2'd0;
            move_valid <= 1'b0;
            armed      <= 1'b0;
            busy       <= 1'b0;
            last_ok    <= 1'b0;
            last_err   <= 1'b0;
`ifdef SOLITAIRE_MOVE_COUNT_EN
            move_count <= 6'd0;
`endif
        end else begin
            case (r_state)
                NAV: begin
                    if (w_sel) begin
                        r_state <= ARMED;
                        armed   <= 1'b1;
                    end else if (w_dir_ev && w_hole_ok) begin
                        cursor_x <= w_tx[2:0];
                        cursor_y <= w_ty[2:0];
                    end
                end
                ARMED: begin
                    if (w_sel) begin
                        r_state <= NAV;
                        armed   <= 1'b0;
                    end else if (w_dir_ev) begin
                        piece_x    <= cursor_x;
                        piece_y    <= cursor_y;
                        direction  <= w_dir;
                        armed      <= 1'b0;
                        move_valid <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (move_ready) begin
                        move_valid <= 1'b0;
                        r_state    <= WAIT;
                    end
                end
                default: begin
                    if (resp_valid) begin
                        last_ok  <= resp_ok;
                        last_err <= !resp_ok;
                        busy     <= 1'b0;
                        r_state  <= NAV;
                        cursor_x <= resp_ok ? w_lx : piece_x;
                        cursor_y <= resp_ok ? w_ly : piece_y;
`ifdef SOLITAIRE_MOVE_COUNT_EN
                        if (resp_ok && move_count != 6'd63) move_count <= move_count + 6'd1;
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_solitaire_move_ctrl.sv
// tb_solitaire_move_ctrl: directed self-checking bench for solitaire_move_ctrl
module tb_solitaire_move_ctrl;
    localparam int DC = 16;
    localparam logic [4:0] L = 5'b00001, R = 5'b00010, U = 5'b00100, D = 5'b01000, S = 5'b10000;
    logic       clk = 0, rst = 0;
    logic [4:0] btn = '0;
    logic       move_ready = 0, resp_valid = 0, resp_ok = 0;
    logic       move_valid, armed, busy, last_ok, last_err;
    logic [2:0] piece_x, piece_y, cursor_x, cursor_y;
    logic [1:0] direction;
`ifdef SOLITAIRE_MOVE_COUNT_EN
    logic [5:0] move_count;
`endif
    int passed = 0, total = 0;
    solitaire_move_ctrl #(.BOARD_WIDTH(7), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .btn_left(btn[0]), .btn_right(btn[1]), .btn_up(btn[2]), .btn_down(btn[3]), .btn_sel(btn[4]),
        .move_valid(move_valid), .move_ready(move_ready),
        .piece_x(piece_x), .piece_y(piece_y), .direction(direction),
        .resp_valid(resp_valid), .resp_ok(resp_ok),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .armed(armed), .busy(busy), .last_ok(last_ok), .last_err(last_err)
`ifdef SOLITAIRE_MOVE_COUNT_EN
        , .move_count(move_count)
`endif
    );
    always #5 clk = ~clk;
    task automatic do_rst();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
    endtask
    task automatic press(input logic [4:0] m);
        @(negedge clk); btn = m;
        repeat (DC + 2) @(negedge clk);
        btn = '0;
        repeat (DC + 2) @(negedge clk);
    endtask
    task automatic handshake();
        @(negedge clk); move_ready = 1;
        @(negedge clk); move_ready = 0;
    endtask
    task automatic respond(input logic ok);
        @(negedge clk); resp_valid = 1; resp_ok = ok;
        @(negedge clk); resp_valid = 0; resp_ok = 0;
    endtask
    task automatic chk_cur(input string n, input logic [2:0] x, input logic [2:0] y);
        total++;
        if ({cursor_x, cursor_y} !== {x, y}) $display("FAIL %s cursor=(%0d,%0d) want (%0d,%0d)", n, cursor_x, cursor_y, x, y);
        else passed++;
    endtask
    task automatic test_reset();
        do_rst();
        total++;
        if ({move_valid, armed, busy, last_ok, last_err, piece_x, piece_y, direction, cursor_x, cursor_y} !==
            {5'b0, 3'd3, 3'd3, 2'd0, 3'd3, 3'd3})
            $display("FAIL reset mv=%b arm=%b busy=%b ok=%b err=%b piece=(%0d,%0d) dir=%0d cur=(%0d,%0d) want zeros, (3,3),0,(3,3)",
                     move_valid, armed, busy, last_ok, last_err, piece_x, piece_y, direction, cursor_x, cursor_y);
        else passed++;
    endtask
    task automatic test_debounce();
        @(negedge clk); btn = R;
        repeat (DC - 1) @(negedge clk);
        btn = '0;
        repeat (DC + 2) @(negedge clk);
        chk_cur("short_press", 3'd3, 3'd3);
    endtask
    task automatic test_navigate();
        press(R); chk_cur("right1", 3'd4, 3'd3);
        press(R); chk_cur("right2", 3'd5, 3'd3);
        press(R); chk_cur("right3", 3'd6, 3'd3);
        press(R); chk_cur("right_edge", 3'd6, 3'd3);
        press(L); press(L); press(U); press(U); press(U);
        chk_cur("walk_to_4_0", 3'd4, 3'd0);
        press(U); chk_cur("up_edge", 3'd4, 3'd0);
        press(D); press(R); chk_cur("corner_hold", 3'd4, 3'd1);
        press(L); chk_cur("to_3_1", 3'd3, 3'd1);
    endtask
    task automatic test_issue();
        press(S);
        total++;
        if (armed !== 1'b1) $display("FAIL arm armed=%b want 1", armed); else passed++;
        @(negedge clk); btn = D;
        repeat (DC - 1) @(negedge clk);
        total++;
        if (move_valid !== 1'b0) $display("FAIL pre_latency mv=%b want 0", move_valid); else passed++;
        @(negedge clk);
        total++;
        if (move_valid !== 1'b0) $display("FAIL event_cycle mv=%b want 0", move_valid); else passed++;
        @(negedge clk);
        total++;
        if ({move_valid, busy, armed} !== 3'b110) $display("FAIL latency mv/busy/arm=%b want 110", {move_valid, busy, armed});
        else passed++;
        btn = '0;
        repeat (DC + 2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({move_valid, piece_x, piece_y, direction} !== {1'b1, 3'd3, 3'd1, 2'd3})
                $display("FAIL stall%0d mv=%b piece=(%0d,%0d) dir=%0d want 1,(3,1),3", i, move_valid, piece_x, piece_y, direction);
            else passed++;
        end
        @(negedge clk); move_ready = 1; resp_valid = 1; resp_ok = 1;
        @(negedge clk); move_ready = 0; resp_valid = 0; resp_ok = 0;
        total++;
        if ({move_valid, busy, last_ok, last_err} !== 4'b0100)
            $display("FAIL handshake mv/busy/ok/err=%b want 0100", {move_valid, busy, last_ok, last_err});
        else passed++;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) $display("FAIL wait_hold busy=%b want 1", busy); else passed++;
    endtask
    task automatic test_response();
        respond(1'b1);
        chk_cur("land_ok", 3'd3, 3'd3);
        total++;
        if ({last_ok, last_err, busy, armed} !== 4'b1000)
            $display("FAIL resp_ok ok/err/busy/arm=%b want 1000", {last_ok, last_err, busy, armed});
        else passed++;
        press(U); press(U); press(S); press(D); handshake(); respond(1'b0);
        chk_cur("reject_stay", 3'd3, 3'd1);
        total++;
        if ({last_ok, last_err, busy} !== 3'b010) $display("FAIL resp_err ok/err/busy=%b want 010", {last_ok, last_err, busy});
        else passed++;
    endtask
    task automatic test_cancel_priority();
        press(S);
        total++;
        if (armed !== 1'b1) $display("FAIL cancel_arm armed=%b want 1", armed); else passed++;
        press(S);
        total++;
        if ({armed, move_valid, busy} !== 3'b000) $display("FAIL cancel arm/mv/busy=%b want 000", {armed, move_valid, busy});
        else passed++;
        press(D); press(D);
        press(S | L);
        chk_cur("prio_nav_cursor", 3'd3, 3'd3);
        total++;
        if (armed !== 1'b1) $display("FAIL prio_nav armed=%b want 1", armed); else passed++;
        press(S | L);
        total++;
        if ({armed, move_valid} !== 2'b00) $display("FAIL prio_armed arm/mv=%b want 00", {armed, move_valid}); else passed++;
    endtask
    task automatic test_busy_drop();
        press(S); press(D);
        press(L);
        chk_cur("busy_cursor", 3'd3, 3'd3);
        total++;
        if ({move_valid, busy, direction} !== {2'b11, 2'd3}) $display("FAIL busy_drop mv/busy/dir=%b want 1111", {move_valid, busy, direction});
        else passed++;
        handshake();
        press(R);
        respond(1'b1);
        chk_cur("busy_land", 3'd3, 3'd5);
        total++;
        if ({last_ok, last_err} !== 2'b10) $display("FAIL busy_resp ok/err=%b want 10", {last_ok, last_err}); else passed++;
    endtask
    task automatic test_reset_midflight();
        press(S); press(U);
        total++;
        if ({move_valid, piece_x, piece_y, direction} !== {1'b1, 3'd3, 3'd5, 2'd2})
            $display("FAIL issue_up mv=%b piece=(%0d,%0d) dir=%0d want 1,(3,5),2", move_valid, piece_x, piece_y, direction);
        else passed++;
        do_rst();
        chk_cur("rst_issue_cur", 3'd3, 3'd3);
        total++;
        if ({move_valid, busy, armed, last_ok} !== 4'b0000) $display("FAIL rst_issue mv/busy/arm/ok=%b want 0000", {move_valid, busy, armed, last_ok});
        else passed++;
        press(S); press(D); handshake();
        do_rst();
        respond(1'b1);
        chk_cur("rst_wait_cur", 3'd3, 3'd3);
        total++;
        if ({move_valid, busy, last_ok} !== 3'b000) $display("FAIL rst_wait mv/busy/ok=%b want 000", {move_valid, busy, last_ok});
        else passed++;
        press(R);
        chk_cur("rst_nav", 3'd4, 3'd3);
    endtask
`ifdef SOLITAIRE_MOVE_COUNT_EN
    task automatic test_move_count();
        do_rst();
        total++;
        if (move_count !== 6'd0) $display("FAIL count_rst count=%0d want 0", move_count); else passed++;
        press(S); press(L); handshake(); respond(1'b1);
        press(S); press(R); handshake(); respond(1'b1);
        press(S); press(U); handshake(); respond(1'b0);
        total++;
        if (move_count !== 6'd2) $display("FAIL count count=%0d want 2", move_count); else passed++;
    endtask
`endif
    initial begin
        test_reset();
        test_debounce();
        test_navigate();
        test_issue();
        test_response();
        test_cancel_priority();
        test_busy_drop();
        test_reset_midflight();
`ifdef SOLITAIRE_MOVE_COUNT_EN
        test_move_count();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
